// File: rtl/square_pipelined_if.sv
// Operand/result bundle for square_pipelined. Valid-only handshake: in_valid
// qualifies x on every edge with en=1, out_valid qualifies osquare/odebug; there is no ready.
interface square_pipelined_if #(
  parameter int BITS = 8
);
  logic              en;
  logic              in_valid;
  logic [BITS-1:0]   x;
  logic              out_valid;
  logic [2*BITS-1:0] osquare;
  logic [BITS-1:0]   odebug;

  modport master (
    output en, in_valid, x,
    input  out_valid, osquare, odebug
  );

  modport slave (
    input  en, in_valid, x,
    output out_valid, osquare, odebug
  );
endinterface

// File: rtl/square_pipelined.sv
// Pipelined unsigned squarer: stage k adds the (k-1)-th shifted partial product,
// so the last stage holds x*x exactly alongside a copy of its operand.
module square_pipelined #(
  parameter int BITS = 8,
  parameter int UP   = BITS - 1,
  parameter int OUP  = 2 * BITS - 1
) (
  input logic             clk,
  input logic             rst_n,
  square_pipelined_if.slave bus
);

  logic         v   [1:BITS];
  logic [UP:0]  xs  [1:BITS];
  logic [OUP:0] acc [1:BITS];
  logic [OUP:0] pp  [1:BITS];

  // Partial product entering each stage, taken from that stage's input operand.
  assign pp[1] = bus.x[0] ? {{BITS{1'b0}}, bus.x} : '0;

  for (genvar k = 2; k <= BITS; k++) begin : g_pp
    assign pp[k] = xs[k-1][k-1] ? ({{BITS{1'b0}}, xs[k-1]} << (k - 1)) : '0;
  end

  // en=0 freezes every stage, valid bits included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= BITS; k++) begin
        v[k]   <= 1'b0;
        xs[k]  <= '0;
        acc[k] <= '0;
      end
    end else if (bus.en) begin
      v[1]   <= bus.in_valid;
      xs[1]  <= bus.x;
      acc[1] <= pp[1];
      for (int k = 2; k <= BITS; k++) begin
        v[k]   <= v[k-1];
        xs[k]  <= xs[k-1];
        acc[k] <= acc[k-1] + pp[k];
      end
    end
  end

  assign bus.out_valid = v[BITS];
  assign bus.osquare   = acc[BITS];
  assign bus.odebug    = xs[BITS];

endmodule

// File: tb/tb_square_pipelined.sv
// Scoreboard bench for square_pipelined: driver pushes {x, x*x} plus the enabled-edge
// index of capture; an independent monitor pops on every out_valid.
module tb_square_pipelined;
  localparam int BITS = 8;
  localparam int LAT  = BITS;

  logic clk;
  logic rst_n;

  square_pipelined_if #(.BITS(BITS)) bus ();

  square_pipelined #(.BITS(BITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [3*BITS-1:0] exp_q[$];
  int                cap_q[$];
  int n_vec     = 0;
  int n_bad     = 0;
  int en_edges  = 0;
  int n_pushed  = 0;
  int n_popped  = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver
  task automatic drive(input logic e, input logic iv, input logic [BITS-1:0] d);
    logic [2*BITS-1:0] sq;
    @(negedge clk);
    bus.en       = e;
    bus.in_valid = iv;
    bus.x        = d;
    if (e && iv && rst_n) begin
      sq = (2*BITS)'(int'(d) * int'(d));
      exp_q.push_back({d, sq});
      cap_q.push_back(en_edges + 1);
      n_pushed++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, BITS'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * LAT; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    check("drain_empty", exp_q.size(), 0);
    check("result_count", n_popped, n_pushed);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_osquare", bus.osquare, 0);
    check("async_rst_odebug", bus.odebug, 0);
    exp_q.delete();
    cap_q.delete();
    n_pushed = 0;
    n_popped = 0;
    #4 rst_n = 1'b1;
  endtask

  // monitor
  logic              prev_v;
  logic [2*BITS-1:0] prev_sq;
  logic [BITS-1:0]   prev_x;
  initial begin
    logic              en_s;
    logic              rst_s;
    logic [3*BITS-1:0] e;
    int                c;
    prev_v  = 1'b0;
    prev_sq = '0;
    prev_x  = '0;
    forever begin
      @(posedge clk);
      en_s  = bus.en;
      rst_s = rst_n;
      if (rst_s && en_s) en_edges++;
      #1;
      if (rst_s && rst_n) begin
        if (!en_s) begin
          check("stall_hold_valid", bus.out_valid, prev_v);
          if (prev_v) begin
            check("stall_hold_osquare", bus.osquare, prev_sq);
            check("stall_hold_odebug", bus.odebug, prev_x);
          end
        end else if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            n_popped++;
            check("osquare", bus.osquare, e[2*BITS-1:0]);
            check("odebug", bus.odebug, e[3*BITS-1:2*BITS]);
            check("latency_edge", en_edges, c + LAT - 1);
          end
        end
      end
      prev_v  = bus.out_valid;
      prev_sq = bus.osquare;
      prev_x  = bus.odebug;
    end
  end

  // stimulus
  logic [BITS-1:0] ops [256];
  logic [BITS-1:0] bb  [6];

  initial begin
    int idx;
    logic e;
    logic iv;
    logic [BITS-1:0] t;

    // reset with en/in_valid asserted: nothing may be captured
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.in_valid = 1'b1;
    bus.x        = 8'h05;
    #3;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_osquare", bus.osquare, 0);
    check("reset_odebug", bus.odebug, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    // single 0xFF pulse
    drive(1'b1, 1'b1, 8'hFF);
    idle(12);
    drain();

    // back-to-back
    bb[0] = 8'h00; bb[1] = 8'h01; bb[2] = 8'h02;
    bb[3] = 8'h10; bb[4] = 8'h80; bb[5] = 8'h0F;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, bb[i]);
    drain();

    // bubbles
    drive(1'b1, 1'b1, 8'd3);
    drive(1'b1, 1'b0, 8'd77);
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b1, 1'b0, 8'd200);
    drain();

    // stall right after capture, then stall again while result is shown
    drive(1'b1, 1'b1, 8'hC8);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'(i % 2 == 0), BITS'($urandom));
    idle(LAT - 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, BITS'($urandom));
    drain();

    // mid-flight reset
    drive(1'b1, 1'b1, 8'd7);
    drive(1'b1, 1'b1, 8'd9);
    drive(1'b1, 1'b1, 8'd11);
    idle(2);
    mid_reset();
    idle(20);
    drive(1'b1, 1'b1, 8'd4);
    drain();

    // random sweep of every operand
    for (int i = 0; i < 256; i++) ops[i] = BITS'(i);
    for (int i = 255; i > 0; i--) begin
      idx      = $urandom_range(0, i);
      t        = ops[i];
      ops[i]   = ops[idx];
      ops[idx] = t;
    end
    n_pushed = 0;
    n_popped = 0;
    idx = 0;
    while (idx < 256) begin
      e  = ($urandom_range(0, 4) != 0);
      iv = ($urandom_range(0, 2) != 0);
      drive(e, iv, iv ? ops[idx] : BITS'($urandom));
      if (e && iv) idx++;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
